// File: rtl/vga_timing_monitor.sv
// Receive-side VGA sync checker: measures line/frame timing from HS/VS,
// declares lock when two consecutive frames agree, and classifies the mode.
module vga_timing_monitor #(
  parameter int unsigned CNT_W         = 12,
  parameter int unsigned MODE0_H_TOTAL = 800,
  parameter int unsigned MODE0_V_TOTAL = 525,
  parameter int unsigned MODE1_H_TOTAL = 1056,
  parameter int unsigned MODE1_V_TOTAL = 628
) (
  input  logic             CLOCK_25,
  input  logic             reset,
  input  logic             HS,
  input  logic             VS,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_sync,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_sync,
  output logic             frame_valid,
  output logic             locked,
  output logic [1:0]       mode
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] M0_H     = CNT_W'(MODE0_H_TOTAL);
  localparam logic [CNT_W-1:0] M0_V     = CNT_W'(MODE0_V_TOTAL);
  localparam logic [CNT_W-1:0] M1_H     = CNT_W'(MODE1_H_TOTAL);
  localparam logic [CNT_W-1:0] M1_V     = CNT_W'(MODE1_V_TOTAL);
  localparam logic [1:0]       MODE_NONE = 2'b00;
  localparam logic [1:0]       MODE_0    = 2'b01;
  localparam logic [1:0]       MODE_1    = 2'b10;
  localparam logic [1:0]       MODE_UNK  = 2'b11;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic             hs_s1, hs_s2, hs_prev;
  logic             vs_s1, vs_s2, vs_prev;
  logic [CNT_W-1:0] h_cnt, hs_low_cnt, line_cnt, vs_line_cnt;
  logic [CNT_W-1:0] prev_h, prev_v;
  logic             seen_hs, seen_vs, prev_valid;

  logic             hs_fall_c, hs_rise_c, vs_fall_c, vs_rise_c;
  logic             frame_end_c, match_c, timeout_c;
  logic [CNT_W-1:0] h_total_new_c, v_total_new_c;
  logic [1:0]       mode_new_c;

  // Edge detection and frame-boundary compare; a coincident HS fall belongs to the ending frame.
  always_comb begin
    hs_fall_c     = hs_prev & ~hs_s2;
    hs_rise_c     = ~hs_prev & hs_s2;
    vs_fall_c     = vs_prev & ~vs_s2;
    vs_rise_c     = ~vs_prev & vs_s2;
    frame_end_c   = vs_fall_c & seen_vs;
    timeout_c     = (h_cnt == CNT_MAX);
    h_total_new_c = (hs_fall_c && seen_hs) ? h_cnt : h_total;
    v_total_new_c = hs_fall_c ? sat_inc(line_cnt) : line_cnt;
    match_c       = prev_valid && (h_total_new_c == prev_h) && (v_total_new_c == prev_v);
    mode_new_c    = MODE_NONE;
    if (match_c) begin
      if (h_total_new_c == M0_H && v_total_new_c == M0_V)      mode_new_c = MODE_0;
      else if (h_total_new_c == M1_H && v_total_new_c == M1_V) mode_new_c = MODE_1;
      else                                                     mode_new_c = MODE_UNK;
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      hs_s1       <= 1'b1;
      hs_s2       <= 1'b1;
      hs_prev     <= 1'b1;
      vs_s1       <= 1'b1;
      vs_s2       <= 1'b1;
      vs_prev     <= 1'b1;
      h_cnt       <= '0;
      hs_low_cnt  <= '0;
      line_cnt    <= '0;
      vs_line_cnt <= '0;
      prev_h      <= '0;
      prev_v      <= '0;
      seen_hs     <= 1'b0;
      seen_vs     <= 1'b0;
      prev_valid  <= 1'b0;
      h_total     <= '0;
      h_sync      <= '0;
      v_total     <= '0;
      v_sync      <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      mode        <= MODE_NONE;
    end else begin
      hs_s1   <= HS;
      hs_s2   <= hs_s1;
      hs_prev <= hs_s2;
      vs_s1   <= VS;
      vs_s2   <= vs_s1;
      vs_prev <= vs_s2;

      // Line period and HS pulse width
      if (hs_fall_c) begin
        h_cnt   <= CNT_W'(1);
        seen_hs <= 1'b1;
        if (seen_hs) h_total <= h_cnt;
      end else begin
        h_cnt <= sat_inc(h_cnt);
      end
      if (hs_rise_c) begin
        h_sync     <= hs_low_cnt;
        hs_low_cnt <= '0;
      end else if (!hs_s2) begin
        hs_low_cnt <= sat_inc(hs_low_cnt);
      end

      // Frame height and VS pulse width in lines
      if (vs_fall_c)      line_cnt <= '0;
      else if (hs_fall_c) line_cnt <= sat_inc(line_cnt);
      if (vs_fall_c) seen_vs <= 1'b1;
      if (vs_rise_c) begin
        v_sync      <= vs_line_cnt;
        vs_line_cnt <= '0;
      end else if (!vs_s2 && hs_fall_c) begin
        vs_line_cnt <= sat_inc(vs_line_cnt);
      end

      frame_valid <= frame_end_c;
      if (frame_end_c) begin
        v_total    <= v_total_new_c;
        prev_h     <= h_total_new_c;
        prev_v     <= v_total_new_c;
        prev_valid <= 1'b1;
        locked     <= match_c;
        mode       <= mode_new_c;
      end

      // Lost HS drops lock straight away; measurements keep their last values
      if (timeout_c) begin
        locked <= 1'b0;
        mode   <= MODE_NONE;
      end
    end
  end

endmodule
